// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline hazard controller:
//   - state_e : RUN / SLEEP state of the WFI state machine
//   - act_e   : the single action chosen for the current cycle
//   - ctrl_t  : the bundle of pipeline control outputs produced by an action
//   - act_decode() : maps an action onto its control bundle
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_e;

    // One action per cycle. The priority order is resolved in the top
    // module; this encoding only names the outcome.
    typedef enum logic [3:0] {
        ACT_RESET  = 4'd0,  // reset asserted: everything low
        ACT_FREEZE = 4'd1,  // memory wait: global hold
        ACT_IRQ    = 4'd2,  // interrupt entry
        ACT_FLUSH  = 4'd3,  // taken branch redirect
        ACT_MRET   = 4'd4,  // interrupt return
        ACT_WFI    = 4'd5,  // WFI in RUN: go to sleep
        ACT_LU     = 4'd6,  // load-use bubble
        ACT_RUN    = 4'd7,  // normal advance
        ACT_SLEEP  = 4'd8,  // sleeping, nothing pending
        ACT_WAKE   = 4'd9   // woken without taking the interrupt
    } act_e;

    typedef struct packed {
        logic stall_IF;
        logic stall;
        logic next_pc_sel;
        logic wfi_signal;
        logic intr_ex;
        logic intr_end_ex;
        logic pc_we;
        logic ifid_we;
    } ctrl_t;

    function automatic ctrl_t act_decode(act_e act);
        ctrl_t c;
        c = '0;
        case (act)
            ACT_FREEZE: c.stall_IF = 1'b1;
            ACT_IRQ: begin
                c.intr_ex = 1'b1;
                c.pc_we   = 1'b1;
                c.ifid_we = 1'b1;
            end
            ACT_FLUSH: begin
                c.next_pc_sel = 1'b1;
                c.pc_we       = 1'b1;
                c.ifid_we     = 1'b1;
            end
            ACT_MRET: begin
                c.intr_end_ex = 1'b1;
                c.pc_we       = 1'b1;
                c.ifid_we     = 1'b1;
            end
            ACT_WFI, ACT_SLEEP: c.wfi_signal = 1'b1;
            ACT_LU: c.stall = 1'b1;
            ACT_RUN, ACT_WAKE: begin
                c.pc_we   = 1'b1;
                c.ifid_we = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/load_use_det.sv
// -----------------------------------------------------------------------------
// load_use_det
// Combinational load-use hazard comparator. Flags when the instruction in ID
// reads a register that a load in EX is about to write (x0 never hazards).
// Kept standalone so the forwarding unit can reuse it.
// Ports:
//   id_rs1_i, id_rs2_i         source indices of the ID instruction
//   id_use_rs1_i, id_use_rs2_i ID instruction actually reads that source
//   ex_rd_i                    destination of the EX instruction
//   ex_is_load_i               EX instruction is a load
//   lu_o                       load-use hazard
// -----------------------------------------------------------------------------
module load_use_det #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    output logic              lu_o
);

    logic rd_nz;
    logic hit1;
    logic hit2;

    assign rd_nz = (ex_rd_i != '0);
    assign hit1  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    assign hit2  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    assign lu_o  = ex_is_load_i & rd_nz & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central pipeline control: memory-wait freeze, load-use bubble, taken-branch
// flush, WFI sleep state machine and interrupt entry/return with an
// in-handler flag that blocks nesting. All outputs except in_handler are
// combinational from state, in_handler and inputs.
//
// Optional feature: define PIPE_HAZARD_PERF_EN to add four free-running
// wrap-around event counters (freeze, load-use, flush, sleep cycles).
//
// Ports:
//   clk, rst            clock, async active-low reset
//   im_wait, dm_wait    memory not ready -> global freeze
//   id_rs1/2, id_use_*  ID source registers
//   ex_rd, ex_is_load   EX destination / load flag
//   ex_br_taken         EX taken branch/jump
//   id_is_wfi/mret      ID instruction class
//   intr_pending, mie   external interrupt level and global enable
//   stall_IF            global freeze
//   stall               load-use bubble into ID/EXE
//   next_pc_sel         branch redirect/flush
//   wfi_signal          WFI bubble / sleeping
//   intr_ex, intr_end_ex interrupt entry / return pulses
//   pc_we, ifid_we      PC and IF/ID write enables
//   in_handler          registered: executing an interrupt handler
//   perf_*_cnt          (PIPE_HAZARD_PERF_EN only) event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_wait,
    input  logic              dm_wait,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_br_taken,
    input  logic              id_is_wfi,
    input  logic              id_is_mret,
    input  logic              intr_pending,
    input  logic              mie,
    output logic              stall_IF,
    output logic              stall,
    output logic              next_pc_sel,
    output logic              wfi_signal,
    output logic              intr_ex,
    output logic              intr_end_ex,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              in_handler
`ifdef PIPE_HAZARD_PERF_EN
   ,output logic [CNT_W-1:0]  perf_freeze_cnt,
    output logic [CNT_W-1:0]  perf_lu_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_sleep_cnt
`endif
);

    state_e state_q;
    logic   in_handler_q;
    logic   lu;
    logic   irq;
    act_e   act;
    ctrl_t  ctrl;

    load_use_det #(
        .REG_AW (REG_AW)
    ) u_lu (
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .ex_rd_i      (ex_rd),
        .ex_is_load_i (ex_is_load),
        .lu_o         (lu)
    );

    // Entry is only allowed outside a handler; a held level therefore
    // cannot re-fire until MRET drops in_handler.
    assign irq = intr_pending & mie & ~in_handler_q;

    // Action select. Reset is folded in here so every output is forced low
    // while rst is asserted, independent of the clock.
    always_comb begin
        act = ACT_RUN;
        if (!rst) begin
            act = ACT_RESET;
        end else if (im_wait | dm_wait) begin
            act = ACT_FREEZE;
        end else if (state_q == ST_SLEEP) begin
            // EX was already bubbled when WFI retired, so branch and
            // load-use are not looked at while asleep.
            if (intr_pending) act = irq ? ACT_IRQ : ACT_WAKE;
            else              act = ACT_SLEEP;
        end else if (irq) begin
            act = ACT_IRQ;
        end else if (ex_br_taken) begin
            act = ACT_FLUSH;
        end else if (id_is_mret & in_handler_q) begin
            act = ACT_MRET;
        end else if (id_is_wfi) begin
            act = ACT_WFI;
        end else if (lu) begin
            act = ACT_LU;
        end
    end

    assign ctrl        = act_decode(act);
    assign stall_IF    = ctrl.stall_IF;
    assign stall       = ctrl.stall;
    assign next_pc_sel = ctrl.next_pc_sel;
    assign wfi_signal  = ctrl.wfi_signal;
    assign intr_ex     = ctrl.intr_ex;
    assign intr_end_ex = ctrl.intr_end_ex;
    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign in_handler  = in_handler_q;

    // State and handler flag. A freeze maps to ACT_FREEZE which falls into
    // the hold branch, so pending events are re-evaluated once unfrozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            in_handler_q <= 1'b0;
        end else begin
            case (act)
                ACT_IRQ: begin
                    state_q      <= ST_RUN;
                    in_handler_q <= 1'b1;
                end
                ACT_MRET: in_handler_q <= 1'b0;
                ACT_WFI:  state_q      <= ST_SLEEP;
                ACT_WAKE: state_q      <= ST_RUN;
                default: begin
                    state_q      <= state_q;
                    in_handler_q <= in_handler_q;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Free-running counters, wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_freeze_cnt <= '0;
            perf_lu_cnt     <= '0;
            perf_flush_cnt  <= '0;
            perf_sleep_cnt  <= '0;
        end else begin
            if (stall_IF)             perf_freeze_cnt <= perf_freeze_cnt + 1'b1;
            if (stall)                perf_lu_cnt     <= perf_lu_cnt + 1'b1;
            if (next_pc_sel)          perf_flush_cnt  <= perf_flush_cnt + 1'b1;
            if (state_q == ST_SLEEP)  perf_sleep_cnt  <= perf_sleep_cnt + 1'b1;
        end
    end
`else
    // CNT_W only sizes the perf counters; without them it is just checked
    // for sanity so the parameter stays meaningful.
    if (CNT_W < 1) begin : g_cnt_w_bad
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       im_wait, dm_wait;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
    logic       id_is_wfi, id_is_mret, intr_pending, mie;
    logic       stall_IF, stall, next_pc_sel, wfi_signal;
    logic       intr_ex, intr_end_ex, pc_we, ifid_we, in_handler;

    int n_chk = 0;
    int n_err = 0;
    int acc0, acc1, acc2;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .im_wait      (im_wait),
        .dm_wait      (dm_wait),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .id_is_wfi    (id_is_wfi),
        .id_is_mret   (id_is_mret),
        .intr_pending (intr_pending),
        .mie          (mie),
        .stall_IF     (stall_IF),
        .stall        (stall),
        .next_pc_sel  (next_pc_sel),
        .wfi_signal   (wfi_signal),
        .intr_ex      (intr_ex),
        .intr_end_ex  (intr_end_ex),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .in_handler   (in_handler)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        im_wait = 0; dm_wait = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_br_taken = 0;
        id_is_wfi = 0; id_is_mret = 0; intr_pending = 0; mie = 0;
    endtask

    // Inputs change on the falling edge, outputs are sampled 2ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_lu();
        ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    endtask

    initial begin
        // reset with every event input active: outputs must still be 0
        rst = 0;
        clr_in();
        im_wait = 1; intr_pending = 1; mie = 1; id_is_wfi = 1; ex_br_taken = 1;
        #3;
        chk("rst_stall_IF", stall_IF, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_ifid_we", ifid_we, 0);
        chk("rst_intr_ex", intr_ex, 0);
        chk("rst_next_pc", next_pc_sel, 0);
        chk("rst_wfi", wfi_signal, 0);
        chk("rst_in_handler", in_handler, 0);

        nxt(); clr_in(); rst = 1; #2;
        chk("run_pc_we", pc_we, 1);
        chk("run_ifid_we", ifid_we, 1);
        chk("run_stall", stall, 0);
        chk("run_stall_IF", stall_IF, 0);

        // load-use on rs2
        nxt(); set_lu(); #2;
        chk("lu_stall", stall, 1);
        chk("lu_pc_we", pc_we, 0);
        chk("lu_ifid_we", ifid_we, 0);
        nxt(); clr_in(); #2;
        chk("lu_after_stall", stall, 0);
        chk("lu_after_pc_we", pc_we, 1);
        // rd = x0 never hazards
        nxt(); set_lu(); ex_rd = 0; id_rs2 = 0; #2;
        chk("lu_x0_stall", stall, 0);
        chk("lu_x0_pc_we", pc_we, 1);
        // rs1 match, but rs1 not used -> no hazard; then used -> hazard
        nxt(); clr_in(); ex_is_load = 1; ex_rd = 9; id_rs1 = 9; #2;
        chk("lu_rs1_unused", stall, 0);
        id_use_rs1 = 1; #1;
        chk("lu_rs1_used", stall, 1);

        // branch beats load-use
        nxt(); clr_in(); set_lu(); ex_br_taken = 1; #2;
        chk("br_next_pc", next_pc_sel, 1);
        chk("br_stall", stall, 0);
        chk("br_pc_we", pc_we, 1);

        // interrupt held 10 cycles: one entry pulse
        nxt(); clr_in(); intr_pending = 1; mie = 1;
        acc0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) nxt();
            #2;
            acc0 += int'(intr_ex);
        end
        chk("irq_pulse_count", acc0, 1);
        chk("irq_in_handler", in_handler, 1);
        chk("irq_handler_pc_we", pc_we, 1);
        nxt(); id_is_mret = 1; #2;
        chk("mret_end_ex", intr_end_ex, 1);
        chk("mret_no_intr_ex", intr_ex, 0);
        nxt(); id_is_mret = 0; #2;
        chk("mret_in_handler", in_handler, 0);
        chk("irq_refire", intr_ex, 1);
        chk("irq_refire_end_ex", intr_end_ex, 0);
        nxt(); intr_pending = 0; #2;
        chk("irq2_in_handler", in_handler, 1);
        chk("irq2_no_pulse", intr_ex, 0);
        nxt(); id_is_mret = 1; #2;
        chk("mret2_end_ex", intr_end_ex, 1);
        nxt(); #2;
        // MRET outside a handler is a normal instruction
        chk("mret_nohdl_end_ex", intr_end_ex, 0);
        chk("mret_nohdl_pc_we", pc_we, 1);
        chk("mret_nohdl_in_handler", in_handler, 0);

        // WFI, sleep 20 cycles ignoring branch / load-use, wake with mie=0
        nxt(); clr_in(); id_is_wfi = 1; #2;
        chk("wfi_signal", wfi_signal, 1);
        chk("wfi_pc_we", pc_we, 0);
        acc0 = 0;
        for (int i = 0; i < 20; i++) begin
            nxt(); clr_in();
            if (i == 5) ex_br_taken = 1;
            if (i == 7) set_lu();
            #2;
            if (wfi_signal !== 1'b1 || pc_we !== 1'b0 || ifid_we !== 1'b0 ||
                next_pc_sel !== 1'b0 || stall !== 1'b0) acc0++;
        end
        chk("sleep_hold_bad_cycles", acc0, 0);
        nxt(); intr_pending = 1; mie = 0; #2;
        chk("wake_wfi", wfi_signal, 0);
        chk("wake_pc_we", pc_we, 1);
        chk("wake_intr_ex", intr_ex, 0);
        nxt(); intr_pending = 0; #2;
        chk("wake_run_wfi", wfi_signal, 0);
        chk("wake_run_pc_we", pc_we, 1);

        // WFI woken by an enabled interrupt: entry in the same cycle
        nxt(); id_is_wfi = 1; #2;
        nxt(); id_is_wfi = 0; intr_pending = 1; mie = 1; #2;
        chk("wake_irq_intr_ex", intr_ex, 1);
        chk("wake_irq_wfi", wfi_signal, 0);
        chk("wake_irq_pc_we", pc_we, 1);
        nxt(); intr_pending = 0; #2;
        chk("wake_irq_in_handler", in_handler, 1);
        chk("wake_irq_run", wfi_signal, 0);
        nxt(); id_is_mret = 1; #2;
        nxt(); clr_in(); #2;
        chk("clr1_in_handler", in_handler, 0);

        // freeze defers the interrupt
        nxt(); intr_pending = 1; mie = 1; im_wait = 1;
        acc0 = 0; acc1 = 0; acc2 = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) nxt();
            #2;
            acc0 += int'(intr_ex);
            acc1 += int'(stall_IF);
            acc2 += int'(pc_we) + int'(ifid_we);
        end
        chk("frz_intr_ex", acc0, 0);
        chk("frz_stall_IF", acc1, 3);
        chk("frz_we", acc2, 0);
        chk("frz_in_handler", in_handler, 0);
        nxt(); im_wait = 0; #2;
        chk("frz_release_intr_ex", intr_ex, 1);
        nxt(); intr_pending = 0; dm_wait = 1; id_is_mret = 1; #2;
        chk("dm_stall_IF", stall_IF, 1);
        chk("dm_frz_end_ex", intr_end_ex, 0);
        nxt(); dm_wait = 0; #2;
        chk("dm_release_end_ex", intr_end_ex, 1);
        nxt(); clr_in(); #2;
        chk("clr2_in_handler", in_handler, 0);

        // async reset while sleeping inside a handler
        nxt(); intr_pending = 1; mie = 1; #2;
        nxt(); intr_pending = 0; id_is_wfi = 1; #2;
        nxt(); id_is_wfi = 0; #2;
        chk("pre_rst_wfi", wfi_signal, 1);
        chk("pre_rst_in_handler", in_handler, 1);
        #1 rst = 0;
        #1;
        chk("arst_wfi", wfi_signal, 0);
        chk("arst_in_handler", in_handler, 0);
        chk("arst_pc_we", pc_we, 0);
        nxt(); rst = 1; #2;
        chk("post_rst_wfi", wfi_signal, 0);
        chk("post_rst_pc_we", pc_we, 1);
        chk("post_rst_in_handler", in_handler, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit. It generates the stall, flush, freeze, WFI and interrupt-entry/return controls consumed by the IF/ID and ID/EXE pipeline registers and the PC.
- Combines memory-wait freeze, load-use detection and taken-branch flush.
- Runs a RUN/SLEEP state machine for WFI.
- Keeps an in-handler flag that blocks nested interrupts.
- Sits beside the decode stage.

Parameters:
REG_AW, 5, register-index width
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
im_wait  in  1  instruction memory not ready
dm_wait  in  1  data memory not ready
id_rs1  in  REG_AW  rs1 index of instruction in ID
id_rs2  in  REG_AW  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  destination of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_br_taken  in  1  EX resolved taken branch/jump
id_is_wfi  in  1  ID instruction is WFI
id_is_mret  in  1  ID instruction is MRET
intr_pending  in  1  external interrupt, level
mie  in  1  global interrupt enable
stall_IF  out  1  global freeze: all pipeline registers and PC hold
stall  out  1  load-use bubble into ID/EXE
next_pc_sel  out  1  branch flush / redirect
wfi_signal  out  1  WFI bubble/sleep
intr_ex  out  1  interrupt entry pulse
intr_end_ex  out  1  interrupt return pulse
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
in_handler  out  1  registered: executing handler

Behaviour:
- While rst=0: state=RUN, in_handler=0, counters=0, and every output forced 0.
- All outputs except in_handler are combinational from state, in_handler and inputs. No output has added latency.

Freeze:
- stall_IF = im_wait | dm_wait.
- While stall_IF=1: all other pulse outputs are 0, pc_we=0, ifid_we=0.
- While stall_IF=1, state and in_handler hold; events are evaluated on the first unfrozen cycle.

Load-use condition (LU):
- LU = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).

State RUN, unfrozen. Exactly one action per cycle, highest priority first:
1. IRQ = intr_pending & mie & !in_handler: intr_ex=1, pc_we=1, ifid_we=1; in_handler<=1 next edge.
2. ex_br_taken: next_pc_sel=1, pc_we=1, ifid_we=1; LU ignored.
3. id_is_mret & in_handler: intr_end_ex=1, pc_we=1, ifid_we=1; in_handler<=0.
4. id_is_wfi: wfi_signal=1, pc_we=0, ifid_we=0; state<=SLEEP.
5. LU: stall=1, pc_we=0, ifid_we=0.
6. Otherwise: pc_we=1, ifid_we=1, all pulses 0.

MRET with in_handler=0 is treated as a normal instruction.

State SLEEP:
- wfi_signal=1, pc_we=0, ifid_we=0 every cycle until intr_pending=1.
- On intr_pending=1 with mie & !in_handler: intr_ex=1, pc_we=1, ifid_we=1, in_handler<=1, state<=RUN, same cycle.
- On intr_pending=1 otherwise: wfi_signal=0, pc_we=1, ifid_we=1, state<=RUN. The WFI retires as a NOP.
- ex_br_taken and LU are ignored in SLEEP (EX already bubbled).
- stall_IF freezes SLEEP like RUN.

Pulse width:
- intr_ex is at most one cycle per handler entry.
- A level intr_pending held high does not re-fire until intr_end_ex clears in_handler.

Optional Feature:
Macro PIPE_HAZARD_PERF_EN.
- Defined: adds outputs perf_freeze_cnt, perf_lu_cnt, perf_flush_cnt, perf_sleep_cnt, each CNT_W bits.
  - Each increments by 1 on every clock edge its condition holds: stall_IF, stall, next_pc_sel, state==SLEEP.
  - Counters wrap modulo 2^CNT_W, with no saturation.
  - Reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, SLEEP), REG_AW default constant, and a typedef for the action-select encoding.
- Sub-module load_use_det: the combinational LU comparator, reusable by the forwarding unit.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_use_rs2=1, id_rs2=5 -> stall=1, pc_we=0, ifid_we=0 for exactly that cycle. Same with ex_rd=0 -> stall=0.
- Branch vs load-use: ex_br_taken=1 together with the LU condition above -> next_pc_sel=1, stall=0, pc_we=1.
- Interrupt lifecycle:
  - intr_pending=1, mie=1 held for 10 cycles -> intr_ex high exactly 1 cycle and in_handler=1.
  - id_is_mret=1 -> intr_end_ex=1 for 1 cycle, in_handler=0.
  - intr_ex fires again on the next cycle.
- WFI:
  - id_is_wfi=1 -> wfi_signal high.
  - 20 idle cycles -> wfi_signal stays 1, pc_we=0.
  - intr_pending=1, mie=0 -> wfi_signal=0, pc_we=1, intr_ex=0, state RUN.
- Freeze and reset: im_wait=1 for 3 cycles with intr_pending=1, mie=1 -> intr_ex=0 during the freeze, intr_ex=1 on the first cycle after im_wait=0.
- Reset in SLEEP: rst=0 asserted asynchronously mid-cycle -> all outputs 0 immediately, state RUN after release.
